// File: rtl/async_hs_pkg.sv
// Shared types and constants for the two-phase (toggle) handshake clock-domain crossing.
package async_hs_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_VALID = 1'b1
    } rx_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser, async active-low reset to 0.
module cdc_sync_bit
    import async_hs_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < MIN_SYNC_STAGES) begin : g_stage_check
        $error("cdc_sync_bit: STAGES must be at least %0d", MIN_SYNC_STAGES);
    end

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_handshake_2p.sv
// Two-phase toggle handshake CDC for a WIDTH-bit payload with valid/ready on both sides.
// Define ASYNC_HS_RX_DATA_REG_EN to register rx_data in the RX domain.
module async_handshake_2p
    import async_hs_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             tx_clk,
    input  logic             tx_rst_b,
    input  logic             rx_clk,
    input  logic             rx_rst_b,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_stage_check
        $error("async_handshake_2p: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end

    // TX domain
    tx_state_t        r_tx_state, w_tx_state_nxt;
    logic             r_req_tgl, w_req_tgl_nxt;
    logic             r_tx_ready, w_tx_ready_nxt;
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic             w_ack_sync;

    // RX domain
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
    logic             r_ack_tgl, w_ack_tgl_nxt;
    logic             r_prev_req, w_prev_req_nxt;
    logic             w_req_sync;
    logic             w_new_req;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk   (rx_clk),
        .i_rst_b (rx_rst_b),
        .i_d     (r_req_tgl),
        .o_q     (w_req_sync)
    );

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (tx_clk),
        .i_rst_b (tx_rst_b),
        .i_d     (r_ack_tgl),
        .o_q     (w_ack_sync)
    );

    always_ff @(posedge tx_clk or negedge tx_rst_b) begin
        if (!tx_rst_b) begin
            r_tx_state <= TX_IDLE;
            r_req_tgl  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_req_tgl  <= w_req_tgl_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_req_tgl_nxt  = r_req_tgl;
        w_tx_ready_nxt = r_tx_ready;
        w_hold_nxt     = r_hold;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_ready_nxt = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_hold_nxt     = tx_data;
                    w_req_tgl_nxt  = ~r_req_tgl;
                    w_tx_ready_nxt = 1'b0;
                    w_tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // Ack toggle catching up with req toggle means the payload was consumed.
                w_tx_ready_nxt = 1'b0;
                if (w_ack_sync == r_req_tgl) begin
                    w_tx_ready_nxt = 1'b1;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_ready_nxt = 1'b0;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign tx_ready  = r_tx_ready;
    assign w_new_req = w_req_sync ^ r_prev_req;

    always_ff @(posedge rx_clk or negedge rx_rst_b) begin
        if (!rx_rst_b) begin
            r_rx_state <= RX_IDLE;
            r_rx_valid <= 1'b0;
            r_ack_tgl  <= 1'b0;
            r_prev_req <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_ack_tgl  <= w_ack_tgl_nxt;
            r_prev_req <= w_prev_req_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_valid_nxt = r_rx_valid;
        w_ack_tgl_nxt  = r_ack_tgl;
        w_prev_req_nxt = r_prev_req;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_new_req) begin
                    w_rx_valid_nxt = 1'b1;
                    w_prev_req_nxt = w_req_sync;
                    w_rx_state_nxt = RX_VALID;
                end
            end
            RX_VALID: begin
                // Ack only on consumption, which backpressures the TX side.
                if (rx_ready) begin
                    w_rx_valid_nxt = 1'b0;
                    w_ack_tgl_nxt  = ~r_ack_tgl;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_valid_nxt = 1'b0;
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign rx_valid = r_rx_valid;

`ifdef ASYNC_HS_RX_DATA_REG_EN
    logic [WIDTH-1:0] r_rx_data;
    logic             w_rx_load;

    assign w_rx_load = (r_rx_state == RX_IDLE) && w_new_req;

    always_ff @(posedge rx_clk or negedge rx_rst_b) begin
        if (!rx_rst_b) begin
            r_rx_data <= '0;
        end else if (w_rx_load) begin
            r_rx_data <= r_hold;
        end
    end

    assign rx_data = r_rx_data;
`else
    // Hold register is frozen from req toggle until ack is seen, so it is safe to expose.
    assign rx_data = r_hold;
`endif

endmodule

// File: tb/tb_async_handshake_2p.sv
// Randomised bench for async_handshake_2p against a FIFO-order delivery model.
module tb_async_handshake_2p;

    parameter int unsigned WIDTH       = 8;
    parameter int unsigned SYNC_STAGES = 2;
    localparam int TIMEOUT = 4000;

    logic             tx_clk = 1'b0;
    logic             rx_clk = 1'b0;
    logic             tx_rst_b;
    logic             rx_rst_b;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    int tx_half = 50;
    int rx_half = 140;

    always #(tx_half) tx_clk = ~tx_clk;
    always #(rx_half) rx_clk = ~rx_clk;

    async_handshake_2p #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .tx_clk   (tx_clk),
        .tx_rst_b (tx_rst_b),
        .rx_clk   (rx_clk),
        .rx_rst_b (rx_rst_b),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted words must come out once each, in order.
    logic [WIDTH-1:0] exp_q[$];
    int               sent_cnt = 0;
    int               rcv_cnt  = 0;

    logic             rx_en      = 1'b0;
    int               rx_mode    = 1;  // 0 stall, 1 always ready, 2 random
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // RX consumer: a word is consumed at an edge where valid and ready were both high before it.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge rx_clk);
            if (rx_en && prev_valid && rx_ready) begin
                rcv_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("rx_extra_word", 64'(rcv_cnt), 64'(sent_cnt));
                end else begin
                    check_eq("rx_data_order", 64'(prev_data), 64'(exp_q.pop_front()));
                end
            end
            #1;
            prev_valid = rx_valid;
            prev_data  = rx_data;
            case (rx_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tx_send(input logic [WIDTH-1:0] w, input bit keep);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < TIMEOUT) begin
            @(posedge tx_clk);
            #1;
            n++;
        end
        check_eq("tx_ready_wait", 64'(tx_ready), 64'd1);
        if (tx_ready === 1'b1) begin
            @(posedge tx_clk);
            exp_q.push_back(w);
            sent_cnt++;
            #1;
            if (!keep) tx_valid = 1'b0;
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tx_ready !== 1'b1) && n < TIMEOUT) begin
            @(posedge tx_clk);
            #1;
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_tx_ready"}, 64'(tx_ready), 64'd1);
    endtask

    task automatic do_reset();
        rx_en    = 1'b0;
        tx_valid = 1'b0;
        tx_rst_b = 1'b0;
        rx_rst_b = 1'b0;
        repeat (3) @(posedge rx_clk);
        #2;
        check_eq("rst_tx_ready", 64'(tx_ready), 64'd0);
        check_eq("rst_rx_valid", 64'(rx_valid), 64'd0);
        exp_q.delete();
        @(negedge tx_clk);
        tx_rst_b = 1'b1;
        rx_rst_b = 1'b1;
        @(posedge tx_clk);
        #2;
        check_eq("rel_tx_ready", 64'(tx_ready), 64'd1);
        check_eq("rel_rx_valid", 64'(rx_valid), 64'd0);
        rx_en = 1'b1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tx_rst_b = 1'b0;
        rx_rst_b = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        do_reset();

        // Single word, consumer always ready: latency in both directions.
        rx_mode = 1;
        tx_send(WIDTH'(8'hA5), 1'b0);
        n = 0;
        do begin
            @(posedge rx_clk);
            #2;
            n++;
        end while (rx_valid !== 1'b1 && n < 50);
        check_eq("rx_valid_latency", 64'(n), 64'(SYNC_STAGES + 1));
        check_eq("rx_data_a5", 64'(rx_data), 64'(WIDTH'(8'hA5)));
        check_eq("tx_ready_busy", 64'(tx_ready), 64'd0);
        @(posedge rx_clk);
        #2;
        check_eq("rx_valid_one_cycle", 64'(rx_valid), 64'd0);
        n = 0;
        do begin
            @(posedge tx_clk);
            #2;
            n++;
        end while (tx_ready !== 1'b1 && n < 50);
        check_eq("tx_ready_latency", 64'(n), 64'(SYNC_STAGES + 1));
        wait_drain("single");

        // Backpressure: hold for 20 rx cycles while tx_data wiggles and tx_valid is ignored.
        rx_mode = 0;
        @(posedge rx_clk);
        #2;
        tx_send(WIDTH'(8'h3C), 1'b0);
        tx_data  = ~WIDTH'(8'h3C);
        tx_valid = 1'b1;
        repeat (10) @(posedge rx_clk);
        #2;
        check_eq("hold_rx_valid_mid", 64'(rx_valid), 64'd1);
        tx_data = WIDTH'(8'h81);
        repeat (10) @(posedge rx_clk);
        #2;
        check_eq("hold_rx_valid", 64'(rx_valid), 64'd1);
        check_eq("hold_rx_data", 64'(rx_data), 64'(WIDTH'(8'h3C)));
        check_eq("hold_tx_ready", 64'(tx_ready), 64'd0);
        tx_valid = 1'b0;
        rx_mode  = 1;
        wait_drain("hold");

        // Streams at both clock ratios with random consumer readiness.
        for (int r = 0; r < 2; r++) begin
            tx_half  = (r == 0) ? 50 : 150;
            rx_half  = (r == 0) ? 150 : 50;
            rx_mode  = 2;
            sent_cnt = 0;
            rcv_cnt  = 0;
            for (int i = 0; i < 256; i++) begin
                tx_send(WIDTH'(i), 1'b1);
            end
            tx_valid = 1'b0;
            wait_drain("stream");
            check_eq("stream_count", 64'(rcv_cnt), 64'd256);
        end
        tx_half = 50;
        rx_half = 140;

        // Joint reset while a word is parked on the RX side.
        rx_mode = 0;
        @(posedge rx_clk);
        #2;
        tx_send(WIDTH'(8'h77), 1'b0);
        n = 0;
        while (rx_valid !== 1'b1 && n < 100) begin
            @(posedge rx_clk);
            #2;
            n++;
        end
        check_eq("pre_reset_rx_valid", 64'(rx_valid), 64'd1);
        do_reset();
        repeat (10) @(posedge rx_clk);
        #2;
        check_eq("no_stale_rx_valid", 64'(rx_valid), 64'd0);
        rx_mode  = 1;
        sent_cnt = 0;
        rcv_cnt  = 0;
        @(posedge rx_clk);
        #2;
        tx_send(WIDTH'(8'h5A), 1'b0);
        wait_drain("post_reset");
        check_eq("post_reset_count", 64'(rcv_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
